iterative_div_unit: RTL and testbench

- Parametrised, multi-cycle radix-2 restoring divider.
- Next-generation replacement for the single-cycle combinational divide path in the ALU arithmetic slice.
- Supports signed and unsigned quotient and remainder at any WIDTH, with valid/ready handshakes on both sides, RISC-V divide-by-zero and overflow results, and a synchronous flush.
- Sits beside the ALU. The issue stage stalls on inReady; writeback consumes outValid.

---
 rtl/iterative_div_unit.sv | 181 ++++++++++++++++++
 tb/tb_iterative_div_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/iterative_div_unit.sv
// Multi-cycle radix-2 restoring divider: signed/unsigned quotient or remainder,
// valid/ready handshakes on both sides, RISC-V divide-by-zero/overflow results.
module iterative_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             flush,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             isSigned,
   input  logic             selRem,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             signed_q, signed_d;
   logic             selrem_q, selrem_d;
   logic             signq_q, signq_d;
   logic             signr_q, signr_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH+1:0] shifted, trial;
   logic [WIDTH-1:0] quo_fix, rem_fix;
   logic [WIDTH-1:0] fin_res;
   logic             fin_dz, fin_ov, fin_load;

   always_comb begin
      a_mag   = (signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
      b_mag   = (signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
      // b_q holds the divisor magnitude once CALC starts
      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = shifted - {2'b00, b_q};
      quo_fix = signq_q ? -quo_q : quo_q;
      rem_fix = signr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      signed_d = signed_q;
      selrem_d = selrem_q;
      signq_d  = signq_q;
      signr_d  = signr_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;
      fin_res  = '0;
      fin_dz   = 1'b0;
      fin_ov   = 1'b0;
      fin_load = 1'b0;

      if (flush) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (inValid) begin
                  a_d      = opA;
                  b_d      = opB;
                  signed_d = isSigned;
                  selrem_d = selRem;
                  state_d  = S_PREP;
               end
            end
            S_PREP: begin
               if (b_q == '0) begin
                  fin_res  = selrem_q ? a_q : '1;
                  fin_dz   = 1'b1;
                  fin_load = 1'b1;
                  state_d  = S_DONE;
               end else if (signed_q && a_q == MIN_INT && b_q == '1) begin
                  fin_res  = selrem_q ? '0 : a_q;
                  fin_ov   = 1'b1;
                  fin_load = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  signq_d = signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                  signr_d = signed_q & a_q[WIDTH-1];
                  quo_d   = a_mag;
                  b_d     = b_mag;
                  rem_d   = '0;
                  cnt_d   = '0;
                  state_d = S_CALC;
               end
            end
            S_CALC: begin
               if (!trial[WIDTH+1]) begin
                  rem_d = trial[WIDTH:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = shifted[WIDTH:0];
                  quo_d = {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = S_FIX;
               end
            end
            S_FIX: begin
               fin_res  = selrem_q ? rem_fix : quo_fix;
               fin_load = 1'b1;
               state_d  = S_DONE;
            end
            S_DONE: begin
               if (outReady) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase

         if (fin_load) begin
            result_d = fin_res;
            flags_d  = {fin_dz, fin_ov, fin_res[WIDTH-1], fin_res == '0};
         end
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         signed_q <= 1'b0;
         selrem_q <= 1'b0;
         signq_q  <= 1'b0;
         signr_q  <= 1'b0;
         rem_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         signed_q <= signed_d;
         selrem_q <= selrem_d;
         signq_q  <= signq_d;
         signr_q  <= signr_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign inReady  = (state_q == S_IDLE);
   assign outValid = (state_q == S_DONE);
   assign result   = result_q;
   assign flags    = flags_q;

endmodule

// File: tb/tb_iterative_div_unit.sv
// Directed bench for iterative_div_unit at WIDTH=32 and WIDTH=8.
module tb_iterative_div_unit;

   logic        clk = 1'b0;
   logic        rstN;
   logic        flush, outReady, isSigned, selRem;
   logic        inValid32, inValid8;
   logic [31:0] opA, opB;

   logic        inReady32, outValid32;
   logic [31:0] result32;
   logic [3:0]  flags32;
   logic        inReady8, outValid8;
   logic [7:0]  result8;
   logic [3:0]  flags8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iterative_div_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .rstN(rstN), .flush(flush), .inValid(inValid32), .inReady(inReady32),
      .opA(opA), .opB(opB), .isSigned(isSigned), .selRem(selRem),
      .outValid(outValid32), .outReady(outReady), .result(result32), .flags(flags32)
   );

   iterative_div_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rstN(rstN), .flush(flush), .inValid(inValid8), .inReady(inReady8),
      .opA(opA[7:0]), .opB(opB[7:0]), .isSigned(isSigned), .selRem(selRem),
      .outValid(outValid8), .outReady(outReady), .result(result8), .flags(flags8)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   task automatic run_op(input bit use8, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic r, input logic [31:0] exp_res,
                         input logic [3:0] exp_flags, input int exp_lat, input bit special,
                         input int hold, input string tag);
      int   lat;
      logic ov;
      opA = a; opB = b; isSigned = s; selRem = r;
      if (use8) inValid8 = 1'b1; else inValid32 = 1'b1;
      @(posedge clk); #1;
      inValid8 = 1'b0; inValid32 = 1'b0;
      lat = 0;
      ov  = 1'b0;
      while (!ov && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         ov = use8 ? outValid8 : outValid32;
      end
      check_val({tag, "_valid"}, ov, 1);
      if (special) check_val({tag, "_lat_le2"}, lat <= 2, 1);
      else         check_val({tag, "_lat"}, lat, exp_lat);
      for (int i = 0; i <= hold; i++) begin
         check_val({tag, "_res"}, use8 ? {24'h0, result8} : result32, exp_res);
         check_val({tag, "_flags"}, use8 ? flags8 : flags32, exp_flags);
         if (hold > 0) begin
            check_val({tag, "_hold_valid"}, use8 ? outValid8 : outValid32, 1);
            check_val({tag, "_hold_inready"}, use8 ? inReady8 : inReady32, 0);
            if (i < hold) begin
               @(posedge clk); #1;
            end
         end
      end
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      check_val({tag, "_drop_valid"}, use8 ? outValid8 : outValid32, 0);
      check_val({tag, "_idle"}, use8 ? inReady8 : inReady32, 1);
   endtask

   initial begin
      int seen;
      rstN = 1'b0; flush = 1'b0; outReady = 1'b0; isSigned = 1'b0; selRem = 1'b0;
      inValid32 = 1'b0; inValid8 = 1'b0; opA = '0; opB = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_inready", inReady32, 1);
      check_val("rst_outvalid", outValid32, 0);
      check_val("rst_result", result32, 0);
      check_val("rst_flags", flags32, 0);
      check_val("rst_inready8", inReady8, 1);
      rstN = 1'b1;
      @(posedge clk); #1;

      run_op(0, 32'd100, 32'd7, 0, 0, 32'd14, 4'b0000, 34, 0, 0, "u_quo");
      run_op(0, 32'd100, 32'd7, 0, 1, 32'd2, 4'b0000, 34, 0, 10, "u_rem_bp");
      run_op(0, 32'hFFFF_FFF9, 32'd2, 1, 0, 32'hFFFF_FFFD, 4'b0010, 34, 0, 0, "s_quo");
      run_op(0, 32'hFFFF_FFF9, 32'd2, 1, 1, 32'hFFFF_FFFF, 4'b0010, 34, 0, 0, "s_rem");
      run_op(0, 32'h1234_5678, 32'd0, 0, 0, 32'hFFFF_FFFF, 4'b1010, 2, 1, 0, "dz_quo");
      run_op(0, 32'h1234_5678, 32'd0, 0, 1, 32'h1234_5678, 4'b1000, 2, 1, 0, "dz_rem");
      run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'h8000_0000, 4'b0110, 2, 1, 0, "ovf_quo");
      run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'h0, 4'b0101, 2, 1, 0, "ovf_rem");

      // flush in the middle of CALC (after 5 iterations)
      opA = 32'd1000; opB = 32'd10; isSigned = 1'b0; selRem = 1'b0; inValid32 = 1'b1;
      @(posedge clk); #1;
      inValid32 = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check_val("flush_idle", inReady32, 1);
      check_val("flush_novalid", outValid32, 0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (outValid32) seen++;
      end
      check_val("flush_no_pulse", seen, 0);

      inValid32 = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      inValid32 = 1'b0; flush = 1'b0;
      check_val("flush_beats_accept", inReady32, 1);

      run_op(0, 32'd1000, 32'd10, 0, 0, 32'd100, 4'b0000, 34, 0, 0, "post_flush");

      // asynchronous reset while iterating
      opA = 32'd100; opB = 32'd7; isSigned = 1'b0; selRem = 1'b0; inValid32 = 1'b1;
      @(posedge clk); #1;
      inValid32 = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      rstN = 1'b0;
      #1;
      check_val("midrst_inready", inReady32, 1);
      check_val("midrst_outvalid", outValid32, 0);
      check_val("midrst_result", result32, 0);
      check_val("midrst_flags", flags32, 0);
      @(posedge clk); #1;
      rstN = 1'b1;
      @(posedge clk); #1;

      run_op(1, 32'd255, 32'd16, 0, 0, 32'd15, 4'b0000, 10, 0, 0, "w8_u_quo");
      run_op(1, 32'd255, 32'd16, 0, 1, 32'd15, 4'b0000, 10, 0, 0, "w8_u_rem");
      run_op(1, 32'h80, 32'hFF, 1, 0, 32'h80, 4'b0110, 2, 1, 0, "w8_ovf");
      run_op(1, 32'hF9, 32'h02, 1, 0, 32'hFD, 4'b0010, 10, 0, 0, "w8_s_quo");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
